// File: rtl/clock_pkg.sv
// Shared types and constants for the real-time clock set-mode controller.
package clock_pkg;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  localparam logic [3:0] POS_HT   = 4'b1000;
  localparam logic [3:0] POS_HU   = 4'b0100;
  localparam logic [3:0] POS_MT   = 4'b0010;
  localparam logic [3:0] POS_MU   = 4'b0001;
  localparam logic [3:0] POS_NONE = 4'b0000;

  localparam logic [3:0] MAX_HT     = 4'd2;
  localparam logic [3:0] MAX_HU_LOW = 4'd3;
  localparam logic [3:0] MAX_HU     = 4'd9;
  localparam logic [3:0] MAX_MT     = 4'd5;
  localparam logic [3:0] MAX_MU     = 4'd9;

  // Hours-units is capped at 3 only in the twenties (20..23).
  function automatic logic [3:0] digit_max(input logic [3:0] pos,
                                           input logic [3:0] hours_tens);
    logic [3:0] mx;
    mx = MAX_MU;
    case (pos)
      POS_HT:  mx = MAX_HT;
      POS_HU:  mx = (hours_tens == 4'd2) ? MAX_HU_LOW : MAX_HU;
      POS_MT:  mx = MAX_MT;
      default: mx = MAX_MU;
    endcase
    return mx;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button path: 2-flop synchronizer, level debounce, 1-cycle press pulse.
module key_debounce #(
  parameter logic [26:0] DEBOUNCE = 27'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic [1:0]  r_sync;
  logic [26:0] r_cnt;
  logic        r_level;
  logic        r_level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], btn};
      r_level_d <= r_level;
      // The count only survives while the synchronized level disagrees.
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEBOUNCE - 27'd1) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 27'd1;
      end
    end
  end

  assign press = r_level & ~r_level_d;

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller: debounced buttons drive setflag/pos/setdigit of the clock core.
// Button press pulses are 1-cycle strobes; outputs update on the edge after a strobe.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter logic [26:0] DEBOUNCE = 27'd1000000,
  parameter logic [31:0] TIMEOUT  = 32'd500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] digit4,
  output logic       setflag,
  output logic [3:0] pos,
  output logic [3:0] setdigit,
  output state_t     dbg_state
);

  logic w_mode;
  logic w_next;
  logic w_inc;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_mode (
    .clk(clk), .rst(rst), .btn(btn_mode), .press(w_mode)
  );
  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_next (
    .clk(clk), .rst(rst), .btn(btn_next), .press(w_next)
  );
  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_inc (
    .clk(clk), .rst(rst), .btn(btn_inc), .press(w_inc)
  );

  state_t      r_state;
  logic [3:0]  r_pos;
  logic [3:0]  r_setdigit;
  logic [31:0] r_idle;

  state_t      w_state_nxt;
  logic [3:0]  w_pos_nxt;
  logic [3:0]  w_setdigit_nxt;
  logic [31:0] w_idle_nxt;
  logic [3:0]  w_pos_rot;
  logic [3:0]  w_seed;
  logic [3:0]  w_max;

  assign w_pos_rot = {r_pos[0], r_pos[3:1]};
  assign w_max     = digit_max(r_pos, digit1);

  always_comb begin
    w_seed = digit1;
    case (w_pos_rot)
      POS_HU:  w_seed = digit2;
      POS_MT:  w_seed = digit3;
      POS_MU:  w_seed = digit4;
      default: w_seed = digit1;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pos_nxt      = r_pos;
    w_setdigit_nxt = r_setdigit;
    w_idle_nxt     = r_idle;
    case (r_state)
      RUN: begin
        w_idle_nxt = '0;
        if (w_mode) begin
          w_state_nxt    = SET;
          w_pos_nxt      = POS_HT;
          w_setdigit_nxt = digit1;
        end
      end
      SET: begin
        // Priority mode > next > inc; any pulse also beats a coinciding timeout.
        if (w_mode) begin
          w_state_nxt = RUN;
          w_pos_nxt   = POS_NONE;
          w_idle_nxt  = '0;
        end else if (w_next) begin
          w_pos_nxt      = w_pos_rot;
          w_setdigit_nxt = w_seed;
          w_idle_nxt     = '0;
        end else if (w_inc) begin
          w_setdigit_nxt = (r_setdigit >= w_max) ? 4'd0 : r_setdigit + 4'd1;
          w_idle_nxt     = '0;
        end else if (r_idle == TIMEOUT - 32'd1) begin
          w_state_nxt = RUN;
          w_pos_nxt   = POS_NONE;
          w_idle_nxt  = '0;
        end else begin
          w_idle_nxt = r_idle + 32'd1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_pos_nxt   = POS_NONE;
        w_idle_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pos      <= POS_NONE;
      r_setdigit <= 4'd0;
      r_idle     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pos      <= w_pos_nxt;
      r_setdigit <= w_setdigit_nxt;
      r_idle     <= w_idle_nxt;
    end
  end

  assign setflag   = (r_state == SET);
  assign pos       = r_pos;
  assign setdigit  = r_setdigit;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios, random buttons, behavioural model.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  localparam int D  = 4;
  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] digit1 = 4'd0;
  logic [3:0] digit2 = 4'd0;
  logic [3:0] digit3 = 4'd0;
  logic [3:0] digit4 = 4'd0;
  logic       setflag;
  logic [3:0] pos;
  logic [3:0] setdigit;
  state_t     dbg_state;

  clock_set_ctrl #(.DEBOUNCE(27'd4), .TIMEOUT(32'd64)) dut (
    .clk(clk), .rst(rst),
    .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
    .digit1(digit1), .digit2(digit2), .digit3(digit3), .digit4(digit4),
    .setflag(setflag), .pos(pos), .setdigit(setdigit), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // Button model: raw is seen two edges late; the accepted level flips after
  // D consecutive edges of disagreement. Set-mode model keeps a digit index.
  bit  m_valid = 1'b0;
  bit  m_d1[3];
  bit  m_d2[3];
  int  m_run[3];
  bit  m_acc[3];
  bit  m_acc_prev[3];
  bit  m_set = 1'b0;
  int  m_idx = 0;
  logic [3:0] m_sd = 4'd0;
  int  m_idle = 0;
  logic [8:0] exp_q[$];

  function automatic logic [3:0] model_max(input int idx, input logic [3:0] ht);
    if (idx == 0) return 4'd2;
    if (idx == 1) return (ht == 4'd2) ? 4'd3 : 4'd9;
    if (idx == 2) return 4'd5;
    return 4'd9;
  endfunction

  always @(posedge clk) begin
    bit raw[3];
    bit pr[3];
    logic [3:0] dg[4];
    logic [3:0] epos;
    raw[0] = btn_mode; raw[1] = btn_next; raw[2] = btn_inc;
    dg[0] = digit1; dg[1] = digit2; dg[2] = digit3; dg[3] = digit4;
    if (rst) begin
      m_valid = 1'b1;
      for (int b = 0; b < 3; b++) begin
        m_d1[b] = 0; m_d2[b] = 0; m_run[b] = 0; m_acc[b] = 0; m_acc_prev[b] = 0;
      end
      m_set = 0; m_idx = 0; m_sd = 4'd0; m_idle = 0;
    end else if (m_valid) begin
      for (int b = 0; b < 3; b++) pr[b] = m_acc[b] && !m_acc_prev[b];
      if (!m_set) begin
        if (pr[0]) begin
          m_set = 1; m_idx = 0; m_sd = dg[0]; m_idle = 0;
        end
      end else if (pr[0]) begin
        m_set = 0; m_idle = 0;
      end else if (pr[1]) begin
        m_idx = (m_idx + 1) % 4; m_sd = dg[m_idx]; m_idle = 0;
      end else if (pr[2]) begin
        m_sd = (m_sd >= model_max(m_idx, dg[0])) ? 4'd0 : m_sd + 4'd1;
        m_idle = 0;
      end else begin
        m_idle = m_idle + 1;
        if (m_idle == TO) begin
          m_set = 0; m_idle = 0;
        end
      end
      for (int b = 0; b < 3; b++) begin
        m_acc_prev[b] = m_acc[b];
        if (m_d2[b] != m_acc[b]) begin
          m_run[b] = m_run[b] + 1;
          if (m_run[b] == D) begin
            m_acc[b] = !m_acc[b];
            m_run[b] = 0;
          end
        end else begin
          m_run[b] = 0;
        end
        m_d2[b] = m_d1[b];
        m_d1[b] = raw[b];
      end
    end
    if (m_valid) begin
      epos = m_set ? (4'b1000 >> m_idx) : 4'b0000;
      exp_q.push_back({m_set, epos, m_sd});
    end
  end

  // ---------------- compare process ----------------
  int         lit_seq = 0;
  int         lit_seen = 0;
  string      lit_name = "";
  logic [8:0] lit_exp = '0;

  always @(negedge clk) begin
    logic [8:0] e;
    logic [8:0] act;
    act = {setflag, pos, setdigit};
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (act !== e || ((dbg_state == SET) !== e[8])) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL model t=%0t got sf/pos/sd=%b/%b/%0d state=%0d want %b/%b/%0d",
                   $time, setflag, pos, setdigit, dbg_state, e[8], e[7:4], e[3:0]);
      end
    end
    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_checks++;
      if (act !== lit_exp) begin
        n_fail++;
        $display("FAIL %s got sf/pos/sd=%b/%b/%0d want %b/%b/%0d", lit_name,
                 setflag, pos, setdigit, lit_exp[8], lit_exp[7:4], lit_exp[3:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic lit_check(input string name, input logic sf, input logic [3:0] p,
                           input logic [3:0] sd);
    @(negedge clk);
    #1;
    lit_name = name;
    lit_exp  = {sf, p, sd};
    lit_seq  = lit_seq + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask);
    @(negedge clk);
    btn_mode = mask[2]; btn_next = mask[1]; btn_inc = mask[0];
    idle(D + 4);
    btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    idle(D + 4);
  endtask

  task automatic set_digits(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    @(negedge clk);
    digit1 = a; digit2 = b; digit3 = c; digit4 = d;
  endtask

  localparam logic [2:0] K_MODE = 3'b100;
  localparam logic [2:0] K_NEXT = 3'b010;
  localparam logic [2:0] K_INC  = 3'b001;

  initial begin
    int rem[3];
    // reset then idle
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    lit_check("reset_state", 1'b0, 4'b0000, 4'd0);
    idle(100);
    lit_check("idle_100", 1'b0, 4'b0000, 4'd0);

    // enter SET and rotate
    set_digits(4'd2, 4'd3, 4'd5, 4'd9);
    press(K_MODE);
    lit_check("enter_set", 1'b1, 4'b1000, 4'd2);
    press(K_NEXT); lit_check("rot_hu", 1'b1, 4'b0100, 4'd3);
    press(K_NEXT); lit_check("rot_mt", 1'b1, 4'b0010, 4'd5);
    press(K_NEXT); lit_check("rot_mu", 1'b1, 4'b0001, 4'd9);
    press(K_NEXT); lit_check("rot_wrap", 1'b1, 4'b1000, 4'd2);

    // increment limits
    set_digits(4'd1, 4'd3, 4'd5, 4'd9);
    press(K_MODE);
    lit_check("exit_holds_sd", 1'b0, 4'b0000, 4'd2);
    press(K_MODE); lit_check("seed_ht1", 1'b1, 4'b1000, 4'd1);
    press(K_INC);  lit_check("inc_ht_2", 1'b1, 4'b1000, 4'd2);
    press(K_INC);  lit_check("inc_ht_wrap", 1'b1, 4'b1000, 4'd0);
    set_digits(4'd2, 4'd3, 4'd5, 4'd9);
    press(K_NEXT); lit_check("seed_hu3", 1'b1, 4'b0100, 4'd3);
    press(K_INC);  lit_check("inc_hu_wrap", 1'b1, 4'b0100, 4'd0);
    press(K_NEXT); lit_check("seed_mt5", 1'b1, 4'b0010, 4'd5);
    press(K_INC);  lit_check("inc_mt_wrap", 1'b1, 4'b0010, 4'd0);

    // bounce rejection
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); btn_inc = 1'b1; idle(2);
      @(negedge clk); btn_inc = 1'b0; idle(2);
    end
    @(negedge clk); btn_inc = 1'b1;
    idle(12);
    lit_check("bounce_one_inc", 1'b1, 4'b0010, 4'd1);
    @(negedge clk); btn_inc = 1'b0;
    idle(12);
    press(K_INC);
    lit_check("second_inc", 1'b1, 4'b0010, 4'd2);

    // simultaneous mode + next
    press(K_MODE | K_NEXT);
    lit_check("mode_beats_next", 1'b0, 4'b0000, 4'd2);

    // timeout
    press(K_MODE);
    lit_check("reenter_set", 1'b1, 4'b1000, 4'd2);
    idle(TO + 16);
    lit_check("timeout_exit", 1'b0, 4'b0000, 4'd2);

    // reset mid-edit
    set_digits(4'd2, 4'd3, 4'd4, 4'd9);
    press(K_MODE);
    press(K_NEXT);
    press(K_NEXT);
    lit_check("pre_reset", 1'b1, 4'b0010, 4'd4);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    lit_check("reset_mid_edit", 1'b0, 4'b0000, 4'd0);

    // random buttons, glitches and digits, checked against the model
    for (int b = 0; b < 3; b++) rem[b] = $urandom_range(1, 12);
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 3; b++) begin
        rem[b] = rem[b] - 1;
        if (rem[b] == 0) begin
          rem[b] = $urandom_range(1, 14);
          case (b)
            0: btn_mode = ~btn_mode;
            1: btn_next = ~btn_next;
            default: btn_inc = ~btn_inc;
          endcase
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        digit1 = 4'($urandom_range(0, 2));
        digit2 = 4'($urandom_range(0, 9));
        digit3 = 4'($urandom_range(0, 5));
        digit4 = 4'($urandom_range(0, 9));
      end
      rst = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    rst = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b0;
    idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Upstream control stage for the 4-digit real-time clock core. It debounces three push-buttons (mode, next, inc) and runs a set-mode state machine. It drives the clock core's `setflag`, one-hot `pos` and `setdigit` inputs, so the user can edit hours and minutes digit by digit. It reads back the core's displayed digits to seed and range-limit each edit.

## Interface
- `DEBOUNCE`, default 27'd1000000: cycles a synchronized button must hold a new level before it is accepted (20 ms at 50 MHz).
- `TIMEOUT`, default 32'd500000000: idle cycles in SET before automatic return to RUN (10 s at 50 MHz).
- `clk`  in  1  system clock, sole clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `btn_mode`  in  1  raw button, active-high, asynchronous to clk.
- `btn_next`  in  1  raw button, active-high, asynchronous.
- `btn_inc`  in  1  raw button, active-high, asynchronous.
- `digit1`..`digit4`  in  4 each  current hours-tens, hours-units, minutes-tens, minutes-units from the clock core.
- `setflag`  out  1  high while in SET.
- `pos`  out  4  one-hot edit position: 1000 hours-tens, 0100 hours-units, 0010 minutes-tens, 0001 minutes-units, 0000 when not editing.
- `setdigit`  out  4  BCD value proposed for the digit at `pos`.

## Operation
- Each button path:
  - 2-flop synchronizer, then debounce counter.
  - The counter resets whenever the synchronized level equals the accepted level.
  - When the counter reaches `DEBOUNCE`, the accepted level toggles.
  - A 0->1 transition of the accepted level emits a 1-cycle press pulse. Release emits nothing.
- FSM states:
  - RUN: `setflag`=0, `pos`=0000.
  - SET: `setflag`=1, `pos` nonzero.
- RUN, mode pulse: go to SET, `pos`<=1000, `setdigit`<=`digit1`.
- SET, mode pulse: go to RUN, `pos`<=0000. `setdigit` holds its last value.
- SET, next pulse:
  - Rotate `pos` right, with 0001 wrapping to 1000.
  - Load `setdigit` from the digit at the new position: 0100 takes `digit2`, 0010 takes `digit3`, 0001 takes `digit4`, 1000 takes `digit1`.
- SET, inc pulse: `setdigit`<=`setdigit`+1, or 0 once the position maximum is reached. Position maxima:
  - hours-tens: 2.
  - hours-units: 3 if `digit1`==2, else 9.
  - minutes-tens: 5.
  - minutes-units: 9.
- Out-of-range `setdigit` on inc: if a loaded value already exceeds the maximum (e.g. units 7 after tens set to 2), inc wraps it to 0.
- Timeout:
  - An idle counter clears on any press pulse and on entry to SET.
  - In SET, reaching `TIMEOUT` returns the FSM to RUN, with the same effect as mode.
  - The counter does not count in RUN.
- Pulses in RUN other than mode: next and inc are ignored.
- Simultaneous pulses in one cycle: priority is mode > next > inc. Lower-priority pulses in that cycle are dropped.
- Timeout coinciding with a pulse: the pulse wins, and the idle counter clears.

## Timing
- Reset values:
  - FSM state RUN.
  - `setflag`=0, `pos`=0000, `setdigit`=0000.
  - All synchronizer, debounce and idle counters cleared; accepted levels 0.
- Reset is sampled only on a clk edge. Asserting it mid-edit returns the block to RUN on the next edge, with no further pulses.
- Button to pulse: a clean raw rise produces a press pulse 2 + `DEBOUNCE` + 1 cycles later, ±1 cycle.
- Pulse to outputs: `setflag`/`pos`/`setdigit` change on the clk edge after the pulse cycle (1-cycle latency).
- Bounce rejection: glitches shorter than `DEBOUNCE` cycles never change the accepted level.
- Output hold: all outputs are registered and stay stable between pulses. The clock core samples them on its slow half-second edge, so it sees glitch-free values.

## Structure
- Shared package `clock_pkg`:
  - FSM state enum {RUN, SET}.
  - Position constants POS_HT=4'b1000, POS_HU=4'b0100, POS_MT=4'b0010, POS_MU=4'b0001, POS_NONE=4'b0000.
  - Digit maxima MAX_HT=2, MAX_HU_LOW=3, MAX_HU=9, MAX_MT=5, MAX_MU=9.
- Sub-module `key_debounce` (params `DEBOUNCE`; ports `clk`, `rst`, `btn`, `press`): synchronizer, debounce counter and edge pulse, instantiated three times.
- The top level holds the FSM, the idle counter and the digit-limit logic.

## Test plan
All scenarios use `DEBOUNCE`=4 and `TIMEOUT`=64.
- Reset then idle:
  - Stimulus: hold rst 3 cycles, release.
  - Required: `setflag`=0, `pos`=0000, `setdigit`=0 throughout; no change for 100 cycles.
- Enter SET and rotate:
  - Stimulus: digits 2,3,5,9 present; clean mode press, then next pressed 4 times.
  - Required: `pos`/`setdigit` = 1000/2, 0100/3, 0010/5, 0001/9, back to 1000/2.
- Increment limits:
  - Stimulus at hours-tens, seeded with 1: inc ×2.
  - Required at hours-tens: 2, then 0.
  - Stimulus at hours-units with `digit1`=2, seeded 3: inc.
  - Required: 0.
  - Stimulus at minutes-tens, seeded 5: inc.
  - Required: 0.
- Bounce rejection:
  - Stimulus: toggle `btn_inc` with 3-cycle pulses 5 times, then hold high.
  - Required: exactly one increment.
  - Stimulus: release then re-press `btn_inc` cleanly.
  - Required: a second increment.
- Simultaneous presses and timeout:
  - Stimulus: mode and next presses aligned in SET.
  - Required: RUN with `pos`=0000.
  - Stimulus: in SET, no presses for 64 cycles.
  - Required: `setflag` falls, `pos`=0000.
- Reset mid-edit:
  - Stimulus: in SET at `pos`=0010 with `setdigit`=4, pulse rst 1 cycle.
  - Required: all outputs return to reset values on the next edge.
